// File: rtl/instr_loader_pkg.sv
// Shared loader/debugger definitions: FSM encoding, UART load protocol constants and word byte order.
package instr_loader_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORD_BYTES    = WORD_W / BYTE_W;
  localparam int unsigned BIDX_W        = 2;
  localparam int unsigned MIN_COUNT     = 1;
  localparam bit          LITTLE_ENDIAN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_COUNT = 3'd1,
    ST_GET_BYTE  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  // Bit offset of byte lane idx inside an instruction word.
  function automatic int unsigned lane_lsb(input logic [BIDX_W-1:0] idx);
    int unsigned k;
    k = 32'(idx);
    return LITTLE_ENDIAN ? BYTE_W * k : BYTE_W * (WORD_BYTES - 1 - k);
  endfunction

endpackage

// File: rtl/instr_loader.sv
// UART program loader: takes a word count then little-endian bytes and writes
// assembled instruction words into instruction memory, with an inter-byte timeout.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned SIZE           = WORD_W,
  parameter int unsigned MEM_SIZE       = 64,
  parameter int unsigned ADDR_WIDTH     = $clog2(MEM_SIZE),
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_n_q;
  logic [CNT_W-1:0]      word_count_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BIDX_W-1:0]     bidx_q;
  logic [SIZE-1:0]       word_q, word_d;
  logic [TO_W-1:0]       to_q;

  logic start_ok, count_bad, timed_out, last_word, accept_byte, count_byte;
  logic we_d, done_d, err_d, busy_d;

  assign start_ok    = i_start && (state_q == ST_IDLE || state_q == ST_ERROR);
  assign count_bad   = (32'(i_rx_data) < MIN_COUNT) || (32'(i_rx_data) > MEM_SIZE);
  assign timed_out   = 32'(to_q) >= TIMEOUT_CYCLES;
  assign last_word   = CNT_W'(word_count_q + CNT_W'(1)) == count_n_q;
  assign count_byte  = i_rx_valid && state_q == ST_GET_COUNT;
  // A byte landing in the WRITE cycle already belongs to the next word.
  assign accept_byte = i_rx_valid &&
                       (state_q == ST_GET_BYTE || (state_q == ST_WRITE && !last_word));

  always_comb begin
    word_d = word_q;
    if (accept_byte) word_d[lane_lsb(bidx_q) +: BYTE_W] = i_rx_data;
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (i_start) state_d = ST_GET_COUNT;
      ST_GET_COUNT: begin
        if (i_rx_valid)     state_d = count_bad ? ST_ERROR : ST_GET_BYTE;
        else if (timed_out) state_d = ST_ERROR;
      end
      ST_GET_BYTE: begin
        if (i_rx_valid) begin
          if (bidx_q == BIDX_W'(WORD_BYTES - 1)) state_d = ST_WRITE;
        end else if (timed_out) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE:     state_d = last_word ? ST_DONE : ST_GET_BYTE;
      ST_DONE:      state_d = ST_IDLE;
      ST_ERROR:     if (i_start) state_d = ST_GET_COUNT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode, registered below so each flag lines up with its state
  always_comb begin
    we_d   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = 1'b1;
    unique case (state_d)
      ST_WRITE: we_d   = 1'b1;
      ST_DONE:  begin done_d = 1'b1; busy_d = 1'b0; end
      ST_ERROR: begin err_d  = 1'b1; busy_d = 1'b0; end
      ST_IDLE:  busy_d = 1'b0;
      default:  busy_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_write_enable <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_busy         <= 1'b0;
      o_write_addr   <= '0;
      o_write_data   <= '0;
    end else begin
      o_write_enable <= we_d;
      o_done         <= done_d;
      o_error        <= err_d;
      o_busy         <= busy_d;
      if (we_d) begin
        o_write_addr <= addr_q;
        o_write_data <= word_d;
      end
    end
  end

  // Load datapath: count, address, byte lane, word assembly and timeout
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_n_q    <= '0;
      word_count_q <= '0;
      addr_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      to_q         <= '0;
    end else if (start_ok) begin
      count_n_q    <= '0;
      word_count_q <= '0;
      addr_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      to_q         <= '0;
    end else begin
      if (count_byte && !count_bad) count_n_q <= CNT_W'(i_rx_data);
      if (accept_byte) begin
        word_q <= word_d;
        bidx_q <= BIDX_W'(bidx_q + BIDX_W'(1));
      end
      if (state_q == ST_WRITE) begin
        word_count_q <= CNT_W'(word_count_q + CNT_W'(1));
        if (!last_word) addr_q <= ADDR_WIDTH'(addr_q + ADDR_WIDTH'(1));
      end
      if (accept_byte || count_byte) begin
        to_q <= '0;
      end else if ((state_q == ST_GET_COUNT || state_q == ST_GET_BYTE ||
                    state_q == ST_WRITE) && !timed_out) begin
        to_q <= TO_W'(to_q + TO_W'(1));
      end
    end
  end

  assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a byte-stream model predicts every write and done pulse.
module tb_instr_loader;

  localparam int unsigned MEM = 64;
  localparam int unsigned TO  = 40;
  localparam int unsigned AW  = 6;

  logic          i_clk = 1'b0;
  logic          i_reset, i_start, i_rx_valid;
  logic [7:0]    i_rx_data;
  logic          o_write_enable, o_busy, o_done, o_error;
  logic [AW-1:0] o_write_addr;
  logic [31:0]   o_write_data;
  logic [AW:0]   o_word_count;

  instr_loader #(.SIZE(32), .MEM_SIZE(MEM), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_write_enable(o_write_enable), .o_write_addr(o_write_addr),
    .o_write_data(o_write_data), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
  wr_t exp_q[$];

  // Model of the load protocol: 0 idle, 1 awaiting count, 2 receiving data
  int          m_phase = 0;
  int          m_n = 0, m_k = 0, m_addr = 0;
  logic [31:0] m_word = '0;
  int          exp_done_cyc = -1;
  int          exp_done_total = 0;
  int          done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_start();
    m_phase = 1; m_n = 0; m_k = 0; m_addr = 0; m_word = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t w;
    if (m_phase == 1) begin
      if (b == 8'd0 || 32'(b) > MEM) m_phase = 0;
      else begin m_n = int'(b); m_phase = 2; m_k = 0; m_word = '0; end
    end else if (m_phase == 2) begin
      m_word = m_word | (32'(b) << (8 * m_k));
      m_k++;
      if (m_k == 4) begin
        w.addr = m_addr; w.data = m_word; w.cyc = cyc + 1;
        exp_q.push_back(w);
        m_addr++; m_k = 0; m_word = '0;
        if (m_addr == m_n) begin
          exp_done_cyc = cyc + 2;
          exp_done_total++;
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic start_load();
    i_start = 1'b1; model_start();
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_valid = 1'b1; i_rx_data = b; model_byte(b);
    tick();
    i_rx_valid = 1'b0; i_rx_data = 8'hA5;
    repeat (gap) tick();
  endtask

  // Compare every write strobe and done pulse against the model
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_write_enable) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                   o_write_addr, o_write_data, cyc);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 64'(o_write_addr), 64'(e.addr));
          chk("write_data", 64'(o_write_data), 64'(e.data));
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (o_done) begin
        done_seen++;
        chk("done_cycle", 64'(cyc), 64'(exp_done_cyc));
        chk("done_word_count", 64'(o_word_count), 64'(m_addr));
        chk("done_error", 64'(o_error), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"},    64'(o_write_enable), 64'd0);
    chk({tag, "_done"},  64'(o_done),         64'd0);
    chk({tag, "_err"},   64'(o_error),        64'd0);
    chk({tag, "_busy"},  64'(o_busy),         64'd0);
    chk({tag, "_wc"},    64'(o_word_count),   64'd0);
    chk({tag, "_addr"},  64'(o_write_addr),   64'd0);
    chk({tag, "_data"},  64'(o_write_data),   64'd0);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (4) tick();
    chk({tag, "_done_pulses"}, 64'(done_seen), 64'(exp_done_total));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit seen;
    i_reset = 1'b1; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset");
    tick();
    i_reset = 1'b0;
    tick();

    // Nominal two-word load with gaps and an ignored start mid-load
    start_load();
    @(negedge i_clk);
    chk("start_busy", 64'(o_busy), 64'd1);
    chk("start_err", 64'(o_error), 64'd0);
    tick();
    send_byte(8'h02, 1);
    send_byte(8'h78, 1); send_byte(8'h56, 0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    send_byte(8'h34, 2); send_byte(8'h12, 1);
    send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 0);
    settle_and_check("nominal");
    chk("nominal_wc", 64'(o_word_count), 64'd2);
    chk("nominal_hold_addr", 64'(o_write_addr), 64'd1);
    chk("nominal_hold_data", 64'(o_write_data), 64'hDEADBEEF);
    chk("nominal_err", 64'(o_error), 64'd0);

    // Count of zero, then one past memory depth
    start_load();
    send_byte(8'h00, 2);
    chk("count0_err", 64'(o_error), 64'd1);
    chk("count0_busy", 64'(o_busy), 64'd0);
    start_load();
    @(negedge i_clk);
    chk("restart_clears_err", 64'(o_error), 64'd0);
    tick();
    send_byte(8'h41, 2);
    chk("count65_err", 64'(o_error), 64'd1);
    send_byte(8'h01, 1);
    chk("error_ignores_rx", 64'(o_error), 64'd1);

    // Inter-byte timeout, then recovery
    start_load();
    send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    repeat (TO - 5) tick();
    @(negedge i_clk);
    chk("pre_timeout_err", 64'(o_error), 64'd0);
    chk("pre_timeout_busy", 64'(o_busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_error) begin seen = 1'b1; break; end
    end
    chk("timeout_err", 64'(seen), 64'd1);
    tick();
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
    settle_and_check("recover");
    chk("recover_data", 64'(o_write_data), 64'h11223344);

    // Reset after two data bytes, then a clean load at addr 0
    start_load();
    send_byte(8'h02, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    i_reset = 1'b1; m_phase = 0; m_k = 0;
    @(negedge i_clk);
    check_all_zero("midreset");
    tick(); tick();
    i_reset = 1'b0;
    tick();
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h0D, 0); send_byte(8'hF0, 0); send_byte(8'hFE, 0); send_byte(8'hCA, 0);
    settle_and_check("post_reset");
    chk("post_reset_addr", 64'(o_write_addr), 64'd0);
    chk("post_reset_data", 64'(o_write_data), 64'hCAFEF00D);

    // Full memory, back-to-back bytes so each word 0 byte lands in a WRITE cycle
    start_load();
    send_byte(8'd64, 0);
    for (int a = 0; a < 64; a++) begin
      send_byte(8'(a), 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    end
    settle_and_check("full");
    chk("full_wc", 64'(o_word_count), 64'd64);
    chk("full_last_addr", 64'(o_write_addr), 64'd63);
    chk("full_last_data", 64'(o_write_data), 64'd63);
    repeat (10) tick();
    chk("full_no_extra_done", 64'(done_seen), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
